mdu_iter: RTL

//  Parametrised HI/LO multiply-divide unit for the EX stage of the pipelined MIPS core.
//  - Multiply: single-cycle product held for a configurable latency.
//  - Divide: true radix-2 restoring iteration.
//  - Provides a start/busy/done handshake for the hazard unit and a cancel input for exceptions.
//  - HI/LO are architectural; mfhi/mflo read the hi/lo outputs directly.

---
 rtl/mdu_pkg.sv | 43 ++++
 rtl/mdu_div_radix2.sv | 46 ++++
 rtl/mdu_iter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Opcodes, FSM encoding and op classification for the HI/LO multiply-divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate opcodes.
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL     = 2'd1;
  localparam logic [1:0] ST_DIV     = 2'd2;
  localparam logic [1:0] ST_DIV_FIX = 2'd3;

  // How the latched product is combined with {hi,lo} at completion.
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_mode_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_long_op(input logic [3:0] op);
    return is_mul_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/mdu_div_radix2.sv
// Unsigned radix-2 restoring divider datapath: one compare-subtract step per enable.
// After WIDTH steps quo holds the quotient and rem the remainder.
module mdu_div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // The extra top bit of diff is the borrow: set means the trial subtract failed.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (en) begin
      if (!diff[WIDTH]) begin
        rem <= diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// HI/LO multiply-divide unit: held single-cycle multiply, iterative restoring divide.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(WIDTH - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;
  logic               sign_q, sign_r, b_zero;

  logic               accept;
  logic               mul_signed, div_signed, neg_a, neg_b;
  logic [2*WIDTH-1:0] ext_a, ext_b, mul_full, mul_result;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, q_fix, r_fix;

  assign accept = op_valid & ~cancel & (state == ST_IDLE);
  assign start  = accept & is_long_op(op);
  assign busy   = (state != ST_IDLE);

  assign mul_signed = (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
  assign ext_a      = mul_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign ext_b      = mul_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign mul_full   = ext_a * ext_b;

  assign div_signed = (op == MDU_DIV);
  assign neg_a      = div_signed & src_a[WIDTH-1];
  assign neg_b      = div_signed & src_b[WIDTH-1];
  assign mag_a      = neg_a ? -src_a : src_a;
  assign mag_b      = neg_b ? -src_b : src_b;

  mdu_div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (start & is_div_op(op)),
    .en       (state == ST_DIV),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo      (quo),
    .rem      (rem)
  );

  // Divide by zero leaves rem = |a|, so the remainder fix-up alone restores hi = src_a.
  assign q_fix = sign_q ? -quo : quo;
  assign r_fix = sign_r ? -rem : rem;

`ifdef MDU_MADD_EN
  acc_mode_e acc_mode, acc_sel;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_sel = ACC_SET;
    if (op == MDU_MADD || op == MDU_MADDU)      acc_sel = ACC_ADD;
    else if (op == MDU_MSUB || op == MDU_MSUBU) acc_sel = ACC_SUB;
  end

  // The accumulator is read at completion, so an MTHI/MTLO cannot slip in mid-op anyway.
  always_comb begin
    mul_result = prod;
    case (acc_mode)
      ACC_ADD: mul_result = {hi, lo} + prod;
      ACC_SUB: mul_result = {hi, lo} - prod;
      default: mul_result = prod;
    endcase
  end
`else
  assign mul_result = prod;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      prod   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MDU_MADD_EN
      acc_mode <= ACC_SET;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul_op(op)) begin
              state <= ST_MUL;
              cnt   <= MUL_CNT0;
              prod  <= mul_full;
`ifdef MDU_MADD_EN
              acc_mode <= acc_sel;
`endif
            end else if (is_div_op(op)) begin
              state  <= ST_DIV;
              cnt    <= DIV_CNT0;
              sign_q <= neg_a ^ neg_b;
              sign_r <= neg_a;
              b_zero <= (src_b == '0);
            end else if (op == MDU_MTHI) begin
              hi <= src_a;
            end else if (op == MDU_MTLO) begin
              lo <= src_a;
            end
          end
        end
        ST_MUL: begin
          if (cancel) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            {hi, lo} <= mul_result;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (cancel)           state <= ST_IDLE;
          else if (cnt == '0)   state <= ST_DIV_FIX;
          else                  cnt   <= cnt - 1'b1;
        end
        ST_DIV_FIX: begin
          if (!cancel) begin
            hi   <= r_fix;
            lo   <= b_zero ? '1 : q_fix;
            done <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
